// File: rtl/mda_pkg.sv
// mda_pkg: shared geometry defaults, control bytes and state encoding for the MDA text writer
package mda_pkg;
    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 25;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] SPACE = 8'h20;
    typedef enum logic [2:0] {INIT_CLR, IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, CLR} state_e;
endpackage

// File: rtl/mda_cell_sweep.sv
// mda_cell_sweep: row-major cell counter used by every clear and scroll pass
module mda_cell_sweep #(
    parameter int COLS = 80,
    parameter int ROWS = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] start_row,
    input  logic       step,
    output logic [6:0] col,
    output logic [4:0] row,
    output logic       last
);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    logic [6:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start) begin
            col_d = '0;
            row_d = start_row;
        end else if (step) begin
            col_d = (col_q == LAST_COL) ? '0 : col_q + 7'd1;
            row_d = (col_q != LAST_COL) ? row_q : (row_q == LAST_ROW) ? '0 : row_q + 5'd1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
    assign col  = col_q;
    assign row  = row_q;
    assign last = (col_q == LAST_COL) && (row_q == LAST_ROW);
endmodule

// File: rtl/mda_text_writer.sv
// mda_text_writer: turns a byte stream into char-RAM writes with cursor tracking,
// line wrap, scroll-up and form-feed clear.
module mda_text_writer
    import mda_pkg::*;
#(
    parameter int         COLS     = COLS_DEF,
    parameter int         ROWS     = ROWS_DEF,
    parameter logic [7:0] DEF_ATTR = 8'h07
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [7:0] in_attr,
    output logic       ram_we,
    output logic       ram_re,
    output logic [6:0] ram_col,
    output logic [4:0] ram_row,
    output logic [7:0] ram_wcode,
    output logic [7:0] ram_wattr,
    input  logic [7:0] ram_rcode,
    input  logic [7:0] ram_rattr,
    output logic [6:0] cur_col,
    output logic [4:0] cur_row,
    output logic       busy
);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    state_e     state_q, state_d;
    logic [6:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [7:0] code_q, code_d, attr_q, attr_d;
    logic       lf, sw_start, sw_step, sw_last;
    logic [4:0] sw_start_row, sw_row;
    logic [6:0] sw_col;

    mda_cell_sweep #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
        .clk       (clk),
        .rst       (rst),
        .start     (sw_start),
        .start_row (sw_start_row),
        .step      (sw_step),
        .col       (sw_col),
        .row       (sw_row),
        .last      (sw_last)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        code_d       = code_q;
        attr_d       = attr_q;
        lf           = 1'b0;
        sw_start     = 1'b0;
        sw_start_row = '0;
        sw_step      = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_col      = sw_col;
        ram_row      = sw_row;
        ram_wcode    = SPACE;
        ram_wattr    = DEF_ATTR;
        case (state_q)
            INIT_CLR, CLR, SCR_CLR: begin
                ram_we  = 1'b1;
                sw_step = 1'b1;
                if (sw_last) begin
                    state_d = IDLE;
                    col_d   = (state_q == SCR_CLR) ? col_q : '0;
                    row_d   = (state_q == SCR_CLR) ? row_q : '0;
                end
            end
            IDLE: if (in_valid) begin
                case (in_data)
                    CR: col_d = '0;
                    BS: col_d = (col_q == '0) ? col_q : col_q - 7'd1;
                    LF: lf = 1'b1;
                    FF: begin
                        state_d  = CLR;
                        sw_start = 1'b1;
                    end
                    default: begin
                        state_d = PUT;
                        code_d  = in_data;
                        attr_d  = in_attr;
                    end
                endcase
            end
            PUT: begin
                ram_we    = 1'b1;
                ram_col   = col_q;
                ram_row   = row_q;
                ram_wcode = code_q;
                ram_wattr = attr_q;
                state_d   = IDLE;
                col_d     = (col_q == LAST_COL) ? '0 : col_q + 7'd1;
                lf        = (col_q == LAST_COL);
            end
            SCR_RD: begin
                ram_re  = 1'b1;
                state_d = SCR_WR;
            end
            SCR_WR: begin
                ram_we       = 1'b1;
                ram_row      = sw_row - 5'd1;
                ram_wcode    = ram_rcode;
                ram_wattr    = ram_rattr;
                state_d      = sw_last ? SCR_CLR : SCR_RD;
                sw_start     = sw_last;
                sw_start_row = LAST_ROW;
                sw_step      = !sw_last;
            end
            default: state_d = INIT_CLR;
        endcase
        // A line feed on the bottom row becomes a scroll starting from source row 1
        if (lf) begin
            if (row_q == LAST_ROW) begin
                state_d      = SCR_RD;
                sw_start     = 1'b1;
                sw_start_row = 5'd1;
            end else begin
                row_d = row_q + 5'd1;
            end
        end
        if (!rst) begin
            ram_we    = 1'b0;
            ram_re    = 1'b0;
            ram_col   = '0;
            ram_row   = '0;
            ram_wcode = '0;
            ram_wattr = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT_CLR;
            col_q   <= '0;
            row_q   <= '0;
            code_q  <= '0;
            attr_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            code_q  <= code_d;
            attr_q  <= attr_d;
        end
    end

    assign in_ready = rst && (state_q == IDLE);
    assign busy     = rst && (state_q != IDLE);
    assign cur_col  = col_q;
    assign cur_row  = row_q;
endmodule
